serial_detect_ctrl: RTL and testbench

Sequencer that drives a bit-serial sequence-detector FSM from parallel words.
- Accepts a WIDTH-bit word on a valid/ready input and optionally clears the detector.
- Feeds the word LSB-first into the detector and captures the aligned per-bit detector output.
- Returns the captured word plus its ones-count on a valid/ready output.

---
 rtl/sdc_pkg.sv | 15 +
 rtl/sdc_capture_pipe.sv | 59 +++++
 rtl/serial_detect_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_detect_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdc_pkg.sv
// Shared definitions for the serial detector sequencer: state encoding and
// result-count width helper.
package sdc_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] SHIFT  = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] OUTPUT = 3'd4;

    function automatic int unsigned CNT_W(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sdc_capture_pipe.sv
// Realigns detector output to the bits fed in: delays det_en by DET_LAT cycles
// to mark capture cycles, shifts det_out into the result and counts its ones.
module sdc_capture_pipe
    import sdc_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DET_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    det_en,
    input  logic                    det_out,
    output logic [WIDTH-1:0]        result,
    output logic [CNT_W(WIDTH)-1:0] count
);

    localparam int unsigned CW = CNT_W(WIDTH);
    // Keep the delay line at least one bit wide so DET_LAT=0 still elaborates.
    localparam int unsigned DL = (DET_LAT == 0) ? 1 : DET_LAT;

    logic [DL-1:0]    en_dly_q, en_dly_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    count_q, count_d;
    logic             capture;

    assign capture = (DET_LAT == 0) ? det_en : en_dly_q[DL-1];

    always_comb begin
        en_dly_d = (en_dly_q << 1) | DL'(det_en);
        result_d = result_q;
        count_d  = count_q;
        if (clr) begin
            en_dly_d = '0;
            result_d = '0;
            count_d  = '0;
        end else if (capture) begin
            // LSB-first feed: the first captured bit ends up at bit 0.
            result_d = {det_out, result_q[WIDTH-1:1]};
            count_d  = count_q + CW'(det_out);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_dly_q <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            en_dly_q <= en_dly_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

    assign result = result_q;
    assign count  = count_q;

endmodule

// File: rtl/serial_detect_ctrl.sv
// Sequencer that feeds parallel words LSB-first into a bit-serial detector and
// returns the aligned per-bit detector output with its ones-count.
module serial_detect_ctrl
    import sdc_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DET_LAT  = 1,
    parameter int unsigned CLEAR_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WIDTH-1:0]        s_data,
    output logic                    det_clr,
    output logic                    det_en,
    output logic                    det_in,
    input  logic                    det_out,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic [CNT_W(WIDTH)-1:0] m_count,
    output logic                    busy
);

    // One counter serves both the bit index in SHIFT and the drain index in DRAIN.
    localparam int unsigned BW = $clog2(WIDTH + DET_LAT + 1);

    logic [2:0]       state_q, state_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             det_en_q, det_en_d;
    logic             det_in_q, det_in_d;
    logic             det_clr_q, det_clr_d;
    logic             accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_valid) begin
                    accept  = 1'b1;
                    shreg_d = s_data;
                    cnt_d   = '0;
                    state_d = (CLEAR_EN != 0) ? CLEAR : SHIFT;
                end
            end
            CLEAR: state_d = SHIFT;
            SHIFT: begin
                shreg_d = shreg_q >> 1;
                if (cnt_q == BW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = (DET_LAT != 0) ? DRAIN : OUTPUT;
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == BW'(DET_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = OUTPUT;
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            OUTPUT: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Detector strobes are decoded from the next state so they leave flops.
        det_en_d  = (state_d == SHIFT);
        det_in_d  = (state_d == SHIFT) & shreg_d[0];
        det_clr_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            det_en_q  <= 1'b0;
            det_in_q  <= 1'b0;
            det_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            det_en_q  <= det_en_d;
            det_in_q  <= det_in_d;
            det_clr_q <= det_clr_d;
        end
    end

    sdc_capture_pipe #(
        .WIDTH   (WIDTH),
        .DET_LAT (DET_LAT)
    ) u_capture (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .det_en  (det_en_q),
        .det_out (det_out),
        .result  (m_data),
        .count   (m_count)
    );

    assign s_ready = (state_q == IDLE);
    assign m_valid = (state_q == OUTPUT);
    assign busy    = (state_q != IDLE);
    assign det_en  = det_en_q;
    assign det_in  = det_in_q;
    assign det_clr = det_clr_q;

endmodule

// File: tb/tb_serial_detect_ctrl.sv
// Bench for serial_detect_ctrl: four configurations driven by detector models,
// results checked through a scoreboard queue popped by an output monitor.
module tb_serial_detect_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    typedef struct {
        int             k;
        logic [W-1:0]   d;
        logic [CW-1:0]  c;
    } sb_item_t;

    logic clk = 1'b0;
    logic rst;
    logic [3:0]         s_valid, s_ready, det_clr, det_en, det_in, m_valid, m_ready, busy;
    logic [3:0][W-1:0]  s_data, m_data;
    logic [3:0][CW-1:0] m_count;
    logic               det_out0, det_out1, det_out2, det_out3;

    int n_checks = 0;
    int n_fail   = 0;
    sb_item_t sb_q[$];

    always #5 clk = ~clk;

    // dut0: echo/pair, dut1: pair without clear, dut2: comb echo, dut3: 3-stage echo
    serial_detect_ctrl #(.WIDTH(W), .DET_LAT(1), .CLEAR_EN(1)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
        .det_clr(det_clr[0]), .det_en(det_en[0]), .det_in(det_in[0]), .det_out(det_out0),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_count(m_count[0]),
        .busy(busy[0])
    );
    serial_detect_ctrl #(.WIDTH(W), .DET_LAT(1), .CLEAR_EN(0)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
        .det_clr(det_clr[1]), .det_en(det_en[1]), .det_in(det_in[1]), .det_out(det_out1),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_count(m_count[1]),
        .busy(busy[1])
    );
    serial_detect_ctrl #(.WIDTH(W), .DET_LAT(0), .CLEAR_EN(1)) u_dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid[2]), .s_ready(s_ready[2]), .s_data(s_data[2]),
        .det_clr(det_clr[2]), .det_en(det_en[2]), .det_in(det_in[2]), .det_out(det_out2),
        .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]), .m_count(m_count[2]),
        .busy(busy[2])
    );
    serial_detect_ctrl #(.WIDTH(W), .DET_LAT(3), .CLEAR_EN(1)) u_dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid[3]), .s_ready(s_ready[3]), .s_data(s_data[3]),
        .det_clr(det_clr[3]), .det_en(det_en[3]), .det_in(det_in[3]), .det_out(det_out3),
        .m_valid(m_valid[3]), .m_ready(m_ready[3]), .m_data(m_data[3]), .m_count(m_count[3]),
        .busy(busy[3])
    );

    // Detector models
    logic       pair_mode;
    logic       prev0, prev1;
    logic [2:0] echo3;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            det_out0 <= 1'b0;
            prev0    <= 1'b0;
        end else if (!pair_mode) begin
            det_out0 <= det_in[0];
        end else if (det_clr[0]) begin
            det_out0 <= 1'b0;
            prev0    <= 1'b0;
        end else if (det_en[0]) begin
            det_out0 <= det_in[0] & prev0;
            prev0    <= det_in[0];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            det_out1 <= 1'b0;
            prev1    <= 1'b0;
        end else if (det_clr[1]) begin
            det_out1 <= 1'b0;
            prev1    <= 1'b0;
        end else if (det_en[1]) begin
            det_out1 <= det_in[1] & prev1;
            prev1    <= det_in[1];
        end
    end

    assign det_out2 = det_in[2];

    always @(posedge clk or posedge rst) begin
        if (rst) echo3 <= '0;
        else     echo3 <= {echo3[1:0], det_in[3]};
    end
    assign det_out3 = echo3[2];

    // Strobe statistics, sampled mid-cycle
    int         en_tot[4]      = '{default: 0};
    int         rise_tot[4]    = '{default: 0};
    int         clr_tot[4]     = '{default: 0};
    int         clr_at_rise[4] = '{default: 0};
    logic [3:0] en_prev        = '0;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (det_clr[k]) clr_tot[k] <= clr_tot[k] + 1;
            if (det_en[k]) begin
                en_tot[k] <= en_tot[k] + 1;
                if (!en_prev[k]) begin
                    rise_tot[k]    <= rise_tot[k] + 1;
                    clr_at_rise[k] <= clr_tot[k];
                end
            end
            en_prev[k] <= det_en[k];
        end
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        sb_item_t it;
        for (int k = 0; k < 4; k++) begin
            if (m_valid[k] && m_ready[k]) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: dut%0d m_data 0x%0h, none expected",
                             k, m_data[k]);
                end else begin
                    it = sb_q.pop_front();
                    check("sb_instance", k, it.k);
                    check("sb_m_data", m_data[k], it.d);
                    check("sb_m_count", m_count[k], it.c);
                end
            end
        end
    end

    task automatic expect_out(input int k, input logic [W-1:0] d, input logic [CW-1:0] c);
        sb_item_t it;
        it.k = k;
        it.d = d;
        it.c = c;
        sb_q.push_back(it);
    endtask

    // Called on the negedge right after the accept edge; returns the cycle index
    // (accept edge = cycle 0) in which m_valid is first seen.
    task automatic wait_valid(input int k, output int lat);
        lat = 1;
        while (!m_valid[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!m_valid[k]) check("m_valid_timeout", 0, 1);
    endtask

    // Called on a negedge; returns on the negedge where m_valid is first high.
    task automatic send(input int k, input logic [W-1:0] d, input logic [W-1:0] exp_d,
                        input logic [CW-1:0] exp_c, output int lat);
        int n;
        expect_out(k, exp_d, exp_c);
        s_data[k]  = d;
        s_valid[k] = 1'b1;
        n = 0;
        while (!s_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready[k]) check("s_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        s_valid[k] = 1'b0;
        wait_valid(k, lat);
    endtask

    task automatic check_idle(input int k, input string tag);
        check({tag, "_ctrl"}, {s_ready[k], m_valid[k], busy[k], det_en[k], det_in[k], det_clr[k]},
              6'b100000);
        check({tag, "_m_data"}, m_data[k], 0);
        check({tag, "_m_count"}, m_count[k], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, e0, r0, c0, c1, nv;
        rst       = 1'b1;
        s_valid   = '0;
        s_data    = '0;
        m_ready   = '1;
        pair_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) check_idle(k, "reset");

        // Echo, full strobe accounting
        e0 = en_tot[0];
        r0 = rise_tot[0];
        c0 = clr_tot[0];
        send(0, 8'hA5, 8'hA5, 4'd4, lat);
        check("a5_latency", lat, 11);
        check("a5_det_en_cycles", en_tot[0] - e0, 8);
        check("a5_det_en_runs", rise_tot[0] - r0, 1);
        check("a5_det_clr_pulses", clr_tot[0] - c0, 1);
        check("a5_clr_before_en", clr_at_rise[0] - c0, 1);

        // Pair detector with clear between words
        pair_mode = 1'b1;
        send(0, 8'h6E, 8'h4C, 4'd3, lat);
        send(0, 8'hFF, 8'hFE, 4'd7, lat);
        check("ff_latency", lat, 11);
        pair_mode = 1'b0;

        // Pair detector without clear: state carries across words
        c1 = clr_tot[1];
        send(1, 8'h80, 8'h00, 4'd0, lat);
        check("noclr_latency", lat, 10);
        send(1, 8'h01, 8'h01, 4'd1, lat);
        check("noclr_det_clr_pulses", clr_tot[1] - c1, 0);

        // Backpressure with a pending input word
        m_ready[0] = 1'b0;
        send(0, 8'h96, 8'h96, 4'd4, lat);
        s_data[0]  = 8'h3C;
        s_valid[0] = 1'b1;
        expect_out(0, 8'h3C, 4'd4);
        for (int i = 0; i < 5; i++) begin
            check("bp_m_valid", m_valid[0], 1);
            check("bp_m_data", m_data[0], 8'h96);
            check("bp_m_count", m_count[0], 4);
            check("bp_s_ready", s_ready[0], 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 m_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_s_ready_at_handshake", s_ready[0], 0);
        @(negedge clk);
        check("bp_s_ready_bubble", s_ready[0], 1);
        @(posedge clk);
        @(negedge clk);
        s_valid[0] = 1'b0;
        check("bp_busy_after_accept", busy[0], 1);
        wait_valid(0, lat);
        check("bp_latency", lat, 11);

        // Detector latency extremes
        send(2, 8'h5A, 8'h5A, 4'd4, lat);
        check("lat0_latency", lat, 10);
        send(3, 8'h5A, 8'h5A, 4'd4, lat);
        check("lat3_latency", lat, 13);

        // Reset during the 4th SHIFT cycle aborts the word
        @(negedge clk);
        check("mid_s_ready_before", s_ready[0], 1);
        s_data[0]  = 8'h77;
        s_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_in_shift", det_en[0], 1);
        rst = 1'b1;
        #1;
        check_idle(0, "midreset");
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid[0]) nv++;
        end
        check("midreset_no_m_valid", nv, 0);
        send(0, 8'hC3, 8'hC3, 4'd4, lat);
        check("after_reset_latency", lat, 11);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
